// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix pins toward the board plus the
// debounced key outputs consumed by keypad_unit.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] key_coord;
  logic       key_valid;
  logic       key_held;

  // Scanner side: reads rows, drives columns and the debounced key outputs
  modport master (
    input  row_in,
    output col_out, key_coord, key_valid, key_held
  );

  // Board / consumer side
  modport slave (
    output row_in,
    input  col_out, key_coord, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a low column across the matrix, samples
// the synchronized rows, builds a per-frame key code and debounces whole
// frames before reporting {row_val, col_val} active-low codes.
module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);
  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       STAB_MAX = 4'(DEBOUNCE_FRAMES);
  localparam logic [7:0]       NONE     = 8'hFF;

  typedef enum logic {ST_RELEASED, ST_PRESSED} state_t;

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_col_out;
  logic [15:0]      r_acc;
  logic [7:0]       r_cand;
  logic [3:0]       r_stab_cnt;
  logic [7:0]       r_key_coord;
  logic             r_key_valid;
  state_t           r_state;

  logic             w_sample;
  logic             w_frame_end;
  logic [15:0]      w_map;
  logic [4:0]       w_hits;
  logic [7:0]       w_frame_code;
  logic             w_match;
  logic [3:0]       w_stab_next;
  logic [7:0]       w_cand_next;
  logic             w_commit;

  assign w_sample    = (r_div_cnt == DIV_LAST);
  assign w_frame_end = w_sample && (r_col_idx == 2'd3);

  // Pressed-position map (bit col*4+row) including the column sampled now
  assign w_map = r_acc | ({12'd0, ~r_row_sync} << {r_col_idx, 2'b00});

  // Frame code: a single pressed position gives its code, anything else NONE
  always_comb begin
    w_hits       = '0;
    w_frame_code = NONE;
    for (int i = 0; i < 16; i++) begin
      w_hits = w_hits + 5'(w_map[i]);
    end
    if (w_hits == 5'd1) begin
      for (int c = 0; c < 4; c++) begin
        if (w_map[c*4 +: 4] != 4'h0) begin
          w_frame_code = {~w_map[c*4 +: 4], ~(4'b0001 << c)};
        end
      end
    end
  end

  assign w_match     = (w_frame_code == r_cand);
  assign w_stab_next = !w_match ? 4'd1 :
                       (r_stab_cnt >= STAB_MAX) ? STAB_MAX : r_stab_cnt + 4'd1;
  assign w_cand_next = w_match ? r_cand : w_frame_code;
  assign w_commit    = (w_stab_next == STAB_MAX) && (w_cand_next != r_key_coord);

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= kp.row_in;
      r_row_sync <= r_row_meta;
    end
  end

  // Column scan timing and per-frame accumulation of pressed positions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_col_idx <= 2'd0;
      r_col_out <= 4'b1110;
      r_acc     <= '0;
    end else if (w_sample) begin
      r_div_cnt <= '0;
      r_col_idx <= r_col_idx + 2'd1;
      r_col_out <= ~(4'b0001 << (r_col_idx + 2'd1));
      r_acc     <= w_frame_end ? 16'd0 : w_map;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Frame debounce and RELEASED/PRESSED state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand      <= NONE;
      r_stab_cnt  <= 4'd0;
      r_key_coord <= NONE;
      r_key_valid <= 1'b0;
      r_state     <= ST_RELEASED;
    end else begin
      r_key_valid <= 1'b0;
      if (w_frame_end) begin
        r_cand     <= w_cand_next;
        r_stab_cnt <= w_stab_next;
        if (w_commit) begin
          r_key_coord <= w_cand_next;
          r_key_valid <= (w_cand_next != NONE);
          case (r_state)
            ST_RELEASED: if (w_cand_next != NONE) r_state <= ST_PRESSED;
            ST_PRESSED:  if (w_cand_next == NONE) r_state <= ST_RELEASED;
            default:     r_state <= ST_RELEASED;
          endcase
        end
      end
    end
  end

  assign kp.col_out   = r_col_out;
  assign kp.key_coord = r_key_coord;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = (r_state == ST_PRESSED);
endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a keypad matrix model drives the rows from
// the scanned column, and a frame-level reference model predicts outputs.
module tb_keypad_scanner;
  localparam int         SCAN_DIV        = 4;
  localparam int         DEBOUNCE_FRAMES = 3;
  localparam int         FRAME_CYCLES    = 4 * SCAN_DIV;
  localparam logic [7:0] NONE            = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keys;
  logic [3:0]  padRows;
  int          testCount = 0;
  int          failCount = 0;
  int          edgeCount = 0;
  logic [7:0]  expCoord;
  logic [7:0]  hist[$];

  keypad_scanner_if kpIf();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kpIf)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Keypad matrix: a row reads low when a pressed key sits in a driven column
  always_comb begin
    padRows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kpIf.col_out[c]) padRows[r] = 1'b0;
      end
    end
  end
  assign kpIf.row_in = padRows;

  // Key code of a single key at (row, col), keys indexed as row*4+col
  function automatic logic [7:0] keyCode(input int row, input int col);
    return 8'hFF ^ ((8'h10 << row) | (8'h01 << col));
  endfunction

  // What one clean frame reports for a given set of pressed keys
  function automatic logic [7:0] frameCode(input logic [15:0] pressed);
    logic [7:0] code;
    code = NONE;
    if ($countones(pressed) == 1) begin
      for (int p = 0; p < 16; p++) begin
        if (pressed[p]) code = keyCode(p / 4, p % 4);
      end
    end
    return code;
  endfunction

  // Stable code moves to X once the last DEBOUNCE_FRAMES frames all read X
  task automatic modelFrameEnd(input logic [7:0] code, output logic pulse);
    logic allSame;
    pulse = 1'b0;
    hist.push_back(code);
    if (hist.size() > DEBOUNCE_FRAMES) void'(hist.pop_front());
    if (hist.size() == DEBOUNCE_FRAMES) begin
      allSame = 1'b1;
      foreach (hist[i]) if (hist[i] != code) allSame = 1'b0;
      if (allSame && code != expCoord) begin
        expCoord = code;
        pulse    = (code != NONE);
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold a key set for one whole frame, then compare against the model
  task automatic applyStimulus(input logic [15:0] newKeys, input string tag);
    logic [15:0] seenValid;
    int          colErrs;
    int          col;
    logic        pulse;
    keys      = newKeys;
    seenValid = '0;
    colErrs   = 0;
    for (int i = 0; i < FRAME_CYCLES; i++) begin
      @(negedge clk);
      edgeCount++;
      col = (edgeCount / SCAN_DIV) % 4;
      if (kpIf.col_out !== ~(4'b0001 << col)) colErrs++;
      seenValid[i] = kpIf.key_valid;
    end
    modelFrameEnd(frameCode(newKeys), pulse);
    checkOutput({tag, ".valid"}, 32'(seenValid), pulse ? 32'h8000 : 32'h0);
    checkOutput({tag, ".coord"}, 32'(kpIf.key_coord), 32'(expCoord));
    checkOutput({tag, ".held"}, 32'(kpIf.key_held), 32'(expCoord != NONE));
    checkOutput({tag, ".col"}, 32'(colErrs), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".col"}, 32'(kpIf.col_out), 32'h0E);
    checkOutput({tag, ".coord"}, 32'(kpIf.key_coord), 32'hFF);
    checkOutput({tag, ".valid"}, 32'(kpIf.key_valid), 32'h0);
    checkOutput({tag, ".held"}, 32'(kpIf.key_held), 32'h0);
  endtask

  // Release reset on a falling edge so the next rising edge is edge 1
  task automatic releaseReset();
    @(negedge clk);
    rst       = 1'b0;
    edgeCount = 0;
    expCoord  = NONE;
    hist.delete();
  endtask

  localparam logic [15:0] K1    = 16'h0001;
  localparam logic [15:0] K2    = 16'h0002;
  localparam logic [15:0] KA    = 16'h0008;
  localparam logic [15:0] K5    = 16'h0020;
  localparam logic [15:0] KHASH = 16'h4000;

  initial begin
    logic [15:0] rk;
    int          sel;
    int          hold;
    int          p;
    int          q;
    int          bounce[9];

    keys = K5;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    releaseReset();

    // Hold "5" from reset: pulse at edge 48, then silence for 20 frames
    for (int f = 0; f < 3; f++) applyStimulus(K5, "hold5");
    checkOutput("five.code", 32'(kpIf.key_coord), 32'hDD);
    for (int f = 0; f < 20; f++) applyStimulus(K5, "held5");

    // Release "5": NONE commits after three frames without a pulse
    for (int f = 0; f < 3; f++) applyStimulus(16'h0, "rel5");
    checkOutput("rel5.final", 32'(kpIf.key_coord), 32'hFF);

    // Frame-level bounce on "#" never stays three frames, then hold
    bounce = '{1, 0, 1, 1, 0, 1, 0, 1, 0};
    foreach (bounce[i]) applyStimulus(bounce[i] != 0 ? KHASH : 16'h0, "bounce");
    for (int f = 0; f < 4; f++) applyStimulus(KHASH, "hash");
    checkOutput("hash.code", 32'(kpIf.key_coord), 32'h7B);

    // Two keys together read as NONE; releasing "2" leaves "1"
    for (int f = 0; f < 3; f++) applyStimulus(16'h0, "gap");
    for (int f = 0; f < 4; f++) applyStimulus(K1 | K2, "multi");
    checkOutput("multi.code", 32'(kpIf.key_coord), 32'hFF);
    for (int f = 0; f < 3; f++) applyStimulus(K1, "one");
    checkOutput("one.code", 32'(kpIf.key_coord), 32'hEE);

    // Slide "1" -> "2" without a gap: second pulse, held stays high
    for (int f = 0; f < 3; f++) applyStimulus(K1, "slide1");
    for (int f = 0; f < 3; f++) applyStimulus(K2, "slide2");
    checkOutput("slide.code", 32'(kpIf.key_coord), 32'hED);

    // Random key sets held for random frame counts
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      p   = $urandom_range(0, 15);
      q   = (p + $urandom_range(1, 15)) % 16;
      case (sel)
        0:       rk = 16'h0;
        3:       rk = (16'h1 << p) | (16'h1 << q);
        default: rk = 16'h1 << p;
      endcase
      hold = $urandom_range(1, 5);
      for (int f = 0; f < hold; f++) applyStimulus(rk, "rand");
    end

    // Reset on edge 40 while "A" is mid-debounce, then re-debounce
    rst = 1'b1;
    repeat (2) @(negedge clk);
    releaseReset();
    for (int f = 0; f < 2; f++) applyStimulus(KA, "preA");
    repeat (7) @(negedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    releaseReset();
    for (int f = 0; f < 3; f++) applyStimulus(KA, "postA");
    checkOutput("postA.code", 32'(kpIf.key_coord), 32'hE7);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
